serial_subtractor: RTL

//  Bit-serial WIDTH-bit subtractor: computes diff = a - b - bin one bit per clock, LSB first.

---
 rtl/serial_sub_pkg.sv | 12 +
 rtl/full_subtractor.sv | 13 +
 rtl/serial_subtractor.sv | 134 +++++++++++++
 3 files changed

// File: rtl/serial_sub_pkg.sv
// Shared types and limits for the bit-serial subtractor.
package serial_sub_pkg;

  localparam int SERIAL_SUB_MAX_WIDTH = 32;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

endpackage

// File: rtl/full_subtractor.sv
// 1-bit full subtractor cell: x - y - z -> (diff, borrow).
module full_subtractor (
  input  logic x,
  input  logic y,
  input  logic z,
  output logic diff,
  output logic borrow
);

  assign diff   = x ^ y ^ z;
  assign borrow = (~x & y) | (~x & z) | (y & z);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial WIDTH-bit subtractor, diff = a - b - bin, LSB first, one bit per clk.
// Optional signed-overflow output enabled by defining SERIAL_SUB_OVF_EN.
//
// state | meaning
// IDLE  | waiting for start, last result held
// SHIFT | one operand bit pair consumed per cycle, busy=1
// DONE  | one-cycle done pulse, result valid; a new start is accepted here
module serial_subtractor
  import serial_sub_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow_out
`ifdef SERIAL_SUB_OVF_EN
  ,
  output logic             ovf
`endif
);

  // Counter is sized to hold WIDTH so it can never wrap inside an operation.
  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  if (WIDTH < 1 || WIDTH > SERIAL_SUB_MAX_WIDTH) begin : g_width_check
    $error("serial_subtractor: WIDTH out of range");
  end

  state_t           state, state_nxt;
  logic [WIDTH-1:0] a_sr, b_sr;
  logic             brw;
  logic [CW-1:0]    cnt;
  logic             d, bo;
  logic             load, last;

  full_subtractor u_fs (
    .x      (a_sr[0]),
    .y      (b_sr[0]),
    .z      (brw),
    .diff   (d),
    .borrow (bo)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state decode; start is only honoured outside SHIFT.
  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          load      = 1'b1;
          state_nxt = SHIFT;
        end
      end
      SHIFT: begin
        if (cnt == LAST) state_nxt = DONE;
      end
      DONE: begin
        if (start) begin
          load      = 1'b1;
          state_nxt = SHIFT;
        end else begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign busy = (state == SHIFT);
  assign done = (state == DONE);
  assign last = (state == SHIFT) && (cnt == LAST);

  // Operand shift registers, borrow loop, counter and result register.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_sr       <= '0;
      b_sr       <= '0;
      brw        <= 1'b0;
      cnt        <= '0;
      diff       <= '0;
      borrow_out <= 1'b0;
    end else if (load) begin
      a_sr       <= a;
      b_sr       <= b;
      brw        <= bin;
      cnt        <= '0;
      diff       <= '0;
      borrow_out <= 1'b0;
    end else if (state == SHIFT) begin
      // New bit enters at the MSB so the LSB-first result lands aligned after WIDTH shifts.
      diff <= (diff >> 1) | (WIDTH'(d) << (WIDTH - 1));
      a_sr <= a_sr >> 1;
      b_sr <= b_sr >> 1;
      brw  <= bo;
      cnt  <= cnt + 1'b1;
      if (last) borrow_out <= bo;
    end
  end

`ifdef SERIAL_SUB_OVF_EN
  logic a_msb, b_msb;

  // Operand MSBs are latched at load because the shift registers lose them.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_msb <= 1'b0;
      b_msb <= 1'b0;
      ovf   <= 1'b0;
    end else if (load) begin
      a_msb <= a[WIDTH-1];
      b_msb <= b[WIDTH-1];
      ovf   <= 1'b0;
    end else if (last) begin
      ovf <= (a_msb != b_msb) && (d != a_msb);
    end
  end
`endif

endmodule
